// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: state encoding, default
// timing parameters and a counter-width helper.
package stopwatch_ctrl_pkg;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      IDLE   = 2'd1,
      RUN    = 2'd2,
      PAUSED = 2'd3
   } sw_state_e;

   localparam int unsigned DB_CYCLES_DEFAULT = 500000;
   localparam int unsigned TICK_DIV_DEFAULT  = 500000;

   // Width of a counter holding 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// One key: 2-flop synchronizer, stability-counter debouncer and a single-cycle
// press pulse on the debounced 1->0 edge. Keys are active-low; reset = released.
module key_debounce
   import stopwatch_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic clr,
   input  logic key_i,
   output logic press_o
);

   localparam int unsigned     CW       = cnt_width(DB_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          db_q, db_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      // Fires in the same cycle the debounced level falls, so it is one cycle wide.
      press_d = db_q & ~db_d;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         db_q    <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/pause/clear keys drive an
// OFF/IDLE/RUN/PAUSED FSM and a tick divider that holds its phase across pauses.
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
   parameter int unsigned TICK_DIV  = TICK_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       pow,
   input  logic       key_str,
   input  logic       key_pas,
   input  logic       key_rst,
   output logic       run,
   output logic       tick,
   output logic       sclr,
   output logic [1:0] state
);

   localparam int unsigned   DW       = cnt_width(TICK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

   logic          str_ev, pas_ev, rst_ev;
   sw_state_e     state_q, state_d;
   logic          run_q, tick_q, tick_d, sclr_q, sclr_d;
   logic          stay_run;
   logic [DW-1:0] div_q, div_d;

   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_str (
      .clk(clk), .clr(clr), .key_i(key_str), .press_o(str_ev));
   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_pas (
      .clk(clk), .clr(clr), .key_i(key_pas), .press_o(pas_ev));
   key_debounce #(.DB_CYCLES(DB_CYCLES)) u_rst (
      .clk(clk), .clr(clr), .key_i(key_rst), .press_o(rst_ev));

   always_comb begin
      state_d = state_q;
      sclr_d  = 1'b0;
      if (!pow) begin
         state_d = OFF;
      end else begin
         case (state_q)
            OFF: begin
               state_d = IDLE;
               sclr_d  = 1'b1;
            end
            IDLE: begin
               if (rst_ev) begin
                  sclr_d = 1'b1;
               end else if (str_ev) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (rst_ev) begin
                  state_d = IDLE;
                  sclr_d  = 1'b1;
               end else if (pas_ev) begin
                  state_d = PAUSED;
               end
            end
            PAUSED: begin
               if (rst_ev) begin
                  state_d = IDLE;
                  sclr_d  = 1'b1;
               end else if (str_ev) begin
                  state_d = RUN;
               end
            end
         endcase
      end

      // Only cycles spent in RUN and staying in RUN advance the divider, so a
      // tick can never land in the first cycle after leaving RUN.
      stay_run = (state_q == RUN) && (state_d == RUN);
      tick_d   = stay_run && (div_q == DIV_LAST);
      if (state_d == OFF || state_d == IDLE) begin
         div_d = '0;
      end else if (stay_run) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end else begin
         div_d = div_q;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= OFF;
         run_q   <= 1'b0;
         tick_q  <= 1'b0;
         sclr_q  <= 1'b0;
         div_q   <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= (state_d == RUN);
         tick_q  <= tick_d;
         sclr_q  <= sclr_d;
         div_q   <= div_d;
      end
   end

   assign run   = run_q;
   assign tick  = tick_q;
   assign sclr  = sclr_q;
   assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DB_CYCLES=4, TICK_DIV=5: expected
// tick cycles and sclr windows are queued at stimulus time and matched by a monitor.
module tb_stopwatch_ctrl;
   import stopwatch_ctrl_pkg::*;

   localparam int DB = 4;
   localparam int TD = 5;

   typedef struct {
      int lo;
      int hi;
   } win_t;

   logic       clk = 1'b0;
   logic       clr, pow, key_str, key_pas, key_rst;
   logic       run, tick, sclr;
   logic [1:0] state;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   next_tick = 0;
   int   last_sclr = -1;
   int   tick_exp[$];
   win_t sclr_exp[$];

   stopwatch_ctrl #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
      .clk(clk), .clr(clr), .pow(pow),
      .key_str(key_str), .key_pas(key_pas), .key_rst(key_rst),
      .run(run), .tick(tick), .sclr(sclr), .state(state));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard side: every tick/sclr pulse must match the head of its queue.
   always @(negedge clk) begin
      int   e;
      win_t w;
      if (tick === 1'b1) begin
         if (state !== RUN) begin
            n_fail++;
            $display("FAIL tick_outside_run: cycle %0d state %0d, required state %0d", cyc, state, RUN);
         end
         if (sclr === 1'b1) begin
            n_fail++;
            $display("FAIL tick_sclr_overlap: cycle %0d both high, required at most one", cyc);
         end
         if (tick_exp.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_tick: tick at cycle %0d, required none", cyc);
         end else begin
            e = tick_exp.pop_front();
            n_tests++;
            if (cyc !== e) begin
               n_fail++;
               $display("FAIL tick_cycle: tick at cycle %0d, required cycle %0d", cyc, e);
            end
         end
      end
      if (sclr === 1'b1) begin
         last_sclr = cyc;
         if (sclr_exp.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_sclr: sclr at cycle %0d, required none", cyc);
         end else begin
            w = sclr_exp.pop_front();
            n_tests++;
            if (cyc < w.lo || cyc > w.hi) begin
               n_fail++;
               $display("FAIL sclr_cycle: sclr at cycle %0d, required %0d..%0d", cyc, w.lo, w.hi);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input int target);
      for (int i = 0; i < 200 && cyc < target; i++) @(negedge clk);
   endtask

   task automatic wait_leave(input logic [1:0] from, output int at);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (state !== from) begin
            at = cyc;
            return;
         end
      end
      n_tests++;
      n_fail++;
      $display("FAIL wait_leave: state still %0d after 40 cycles, required a change", from);
      at = cyc;
   endtask

   task automatic push_ticks_upto(input int last);
      while (next_tick <= last) begin
         tick_exp.push_back(next_tick);
         next_tick += TD;
      end
   endtask

   // Divider value at cycle y of the current RUN stint.
   function automatic int div_at(input int y);
      return ((y - next_tick) % TD + TD) % TD;
   endfunction

   // Press slot three cycles before a tick: the exit cycle cannot coincide with a tick
   // anywhere inside the +/-1 latency window.
   task automatic press_slot(output int c);
      int t;
      t = next_tick;
      while (t - 3 <= cyc) t += TD;
      push_ticks_upto(t);
      wait_until(t - 3);
      c = cyc;
   endtask

   task automatic test_reset();
      int c;
      clr = 1'b0; pow = 1'b0; key_str = 1'b1; key_pas = 1'b1; key_rst = 1'b1;
      step(3);
      n_tests++; if (state !== OFF) begin n_fail++; $display("FAIL reset_state: got %0d, required %0d", state, OFF); end
      n_tests++; if (run !== 1'b0) begin n_fail++; $display("FAIL reset_run: got %b, required 0", run); end
      n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b, required 0", tick); end
      n_tests++; if (sclr !== 1'b0) begin n_fail++; $display("FAIL reset_sclr: got %b, required 0", sclr); end
      clr = 1'b1;
      step(4);
      n_tests++; if (state !== OFF) begin n_fail++; $display("FAIL off_without_pow: got %0d, required %0d", state, OFF); end
      pow = 1'b1;
      c = cyc;
      sclr_exp.push_back('{c + 1, c + 1});
      step(1);
      n_tests++; if (state !== IDLE) begin n_fail++; $display("FAIL power_up_idle: got %0d, required %0d", state, IDLE); end
      step(15);
      n_tests++; if (state !== IDLE) begin n_fail++; $display("FAIL no_spurious_press: got %0d, required %0d", state, IDLE); end
      n_tests++; if (last_sclr !== c + 1) begin n_fail++; $display("FAIL power_up_sclr: got cycle %0d, required %0d", last_sclr, c + 1); end
   endtask

   task automatic test_start();
      int c, k;
      key_str = 1'b0;
      c = cyc;
      wait_leave(IDLE, k);
      n_tests++; if (state !== RUN) begin n_fail++; $display("FAIL start_state: got %0d, required %0d", state, RUN); end
      n_tests++; if (k - c < DB + 2 || k - c > DB + 4) begin n_fail++; $display("FAIL start_latency: got %0d cycles, required %0d..%0d", k - c, DB + 2, DB + 4); end
      n_tests++; if (run !== 1'b1) begin n_fail++; $display("FAIL start_run: got %b, required 1", run); end
      next_tick = k + TD;
      push_ticks_upto(k + 12);
      step(2);
      key_str = 1'b1;
      wait_until(k + 13);
      n_tests++; if (state !== RUN) begin n_fail++; $display("FAIL release_no_event: got %0d, required %0d", state, RUN); end
      n_tests++; if (tick_exp.size() != 0) begin n_fail++; $display("FAIL start_ticks_seen: %0d pending, required 0", tick_exp.size()); end
   endtask

   task automatic test_rst_in_run();
      int c, j;
      press_slot(c);
      key_rst = 1'b0;
      sclr_exp.push_back('{c + DB + 2, c + DB + 4});
      wait_leave(RUN, j);
      n_tests++; if (state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d, required %0d", state, IDLE); end
      n_tests++; if (run !== 1'b0) begin n_fail++; $display("FAIL rst_run: got %b, required 0", run); end
      step(1);
      n_tests++; if (last_sclr !== j) begin n_fail++; $display("FAIL rst_sclr_cycle: got %0d, required %0d", last_sclr, j); end
      key_rst = 1'b1;
      step(12);
      n_tests++; if (state !== IDLE) begin n_fail++; $display("FAIL rst_stays_idle: got %0d, required %0d", state, IDLE); end
      n_tests++; if (tick_exp.size() + sclr_exp.size() != 0) begin n_fail++; $display("FAIL rst_drained: %0d pending, required 0", tick_exp.size() + sclr_exp.size()); end
   endtask

   task automatic test_bounce();
      int c, k, bad;
      bad = 0;
      key_str = 1'b1;
      for (int i = 0; i < 10; i++) begin
         key_str = ~key_str;
         repeat (2) begin
            @(negedge clk);
            if (state !== IDLE) bad++;
         end
      end
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL bounce_no_event: %0d non-IDLE cycles, required 0", bad); end
      key_str = 1'b0;
      c = cyc;
      wait_leave(IDLE, k);
      n_tests++; if (state !== RUN) begin n_fail++; $display("FAIL bounce_state: got %0d, required %0d", state, RUN); end
      n_tests++; if (k - c < DB + 2 || k - c > DB + 4) begin n_fail++; $display("FAIL bounce_latency: got %0d cycles, required %0d..%0d", k - c, DB + 2, DB + 4); end
      // Divider was cleared by the soft clear, so the phase restarts from zero.
      next_tick = k + TD;
      push_ticks_upto(k + 21);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 15) key_str = 1'b1;
         @(negedge clk);
         if (state !== RUN) bad++;
      end
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL held_single_run: %0d non-RUN cycles, required 0", bad); end
   endtask

   task automatic test_pause_resume();
      int c, p, r, h, bad;
      press_slot(c);
      key_pas = 1'b0;
      wait_leave(RUN, p);
      n_tests++; if (state !== PAUSED) begin n_fail++; $display("FAIL pause_state: got %0d, required %0d", state, PAUSED); end
      n_tests++; if (p - c < DB + 2 || p - c > DB + 4) begin n_fail++; $display("FAIL pause_latency: got %0d cycles, required %0d..%0d", p - c, DB + 2, DB + 4); end
      h = div_at(p - 1);
      step(2);
      key_pas = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (state !== PAUSED || tick !== 1'b0) bad++;
      end
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL pause_hold: %0d bad cycles, required 0", bad); end
      key_str = 1'b0;
      wait_leave(PAUSED, r);
      n_tests++; if (state !== RUN) begin n_fail++; $display("FAIL resume_state: got %0d, required %0d", state, RUN); end
      next_tick = r + TD - h;
      push_ticks_upto(next_tick + TD);
      step(2);
      key_str = 1'b1;
   endtask

   task automatic test_simultaneous();
      int c, p, r, h;
      press_slot(c);
      key_str = 1'b0; key_pas = 1'b0;
      wait_leave(RUN, p);
      n_tests++; if (state !== PAUSED) begin n_fail++; $display("FAIL simul_in_run: got %0d, required %0d", state, PAUSED); end
      h = div_at(p - 1);
      step(2);
      key_str = 1'b1; key_pas = 1'b1;
      step(12);
      key_str = 1'b0; key_pas = 1'b0;
      wait_leave(PAUSED, r);
      n_tests++; if (state !== RUN) begin n_fail++; $display("FAIL simul_in_paused: got %0d, required %0d", state, RUN); end
      next_tick = r + TD - h;
      push_ticks_upto(next_tick + TD);
      step(2);
      key_str = 1'b1; key_pas = 1'b1;
   endtask

   task automatic test_pow_drop();
      int c, t;
      t = next_tick;
      while (t - 1 <= cyc) t += TD;
      push_ticks_upto(t - TD);
      wait_until(t - 1);
      // The divider reads TICK_DIV-1 here; the tick that would follow must be lost.
      pow = 1'b0;
      step(1);
      n_tests++; if (state !== OFF) begin n_fail++; $display("FAIL pow_drop_state: got %0d, required %0d", state, OFF); end
      n_tests++; if (run !== 1'b0) begin n_fail++; $display("FAIL pow_drop_run: got %b, required 0", run); end
      key_str = 1'b0;
      step(DB + 8);
      n_tests++; if (state !== OFF) begin n_fail++; $display("FAIL key_in_off: got %0d, required %0d", state, OFF); end
      key_str = 1'b1;
      step(8);
      pow = 1'b1;
      c = cyc;
      sclr_exp.push_back('{c + 1, c + 1});
      step(1);
      n_tests++; if (state !== IDLE) begin n_fail++; $display("FAIL repower_idle: got %0d, required %0d", state, IDLE); end
      step(1);
      n_tests++; if (last_sclr !== c + 1) begin n_fail++; $display("FAIL repower_sclr: got cycle %0d, required %0d", last_sclr, c + 1); end
      n_tests++; if (tick_exp.size() + sclr_exp.size() != 0) begin n_fail++; $display("FAIL pow_drained: %0d pending, required 0", tick_exp.size() + sclr_exp.size()); end
   endtask

   task automatic test_clr_mid_run();
      int c, k, t;
      key_str = 1'b0;
      wait_leave(IDLE, k);
      n_tests++; if (state !== RUN) begin n_fail++; $display("FAIL clr_run_entry: got %0d, required %0d", state, RUN); end
      next_tick = k + TD;
      step(2);
      key_str = 1'b1;
      t = next_tick;
      while (t - 1 <= cyc) t += TD;
      push_ticks_upto(t - TD);
      wait_until(t - 1);
      #2 clr = 1'b0;
      #1;
      n_tests++; if (state !== OFF) begin n_fail++; $display("FAIL clr_state: got %0d, required %0d", state, OFF); end
      n_tests++; if (run !== 1'b0) begin n_fail++; $display("FAIL clr_run: got %b, required 0", run); end
      n_tests++; if (tick !== 1'b0 || sclr !== 1'b0) begin n_fail++; $display("FAIL clr_pulses: tick %b sclr %b, required 0 0", tick, sclr); end
      step(3);
      clr = 1'b1;
      c = cyc;
      sclr_exp.push_back('{c + 1, c + 1});
      step(1);
      n_tests++; if (state !== IDLE) begin n_fail++; $display("FAIL clr_release_idle: got %0d, required %0d", state, IDLE); end
      step(6);
      n_tests++; if (state !== IDLE) begin n_fail++; $display("FAIL clr_no_event: got %0d, required %0d", state, IDLE); end
      n_tests++; if (tick_exp.size() + sclr_exp.size() != 0) begin n_fail++; $display("FAIL clr_drained: %0d pending, required 0", tick_exp.size() + sclr_exp.size()); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_start();
      test_rst_in_run();
      test_bounce();
      test_pause_resume();
      test_simultaneous();
      test_pow_drop();
      test_clr_mid_run();
      step(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 500000: consecutive stable cycles required to accept a key level change.
REQ-002 Parameter TICK_DIV, default 500000: clk cycles per tick (10 ms at 50 MHz).
REQ-003 The block SHALL provide these ports:
- clk  input  1  system clock; all logic on rising edge.
- clr  input  1  reset, asynchronous, active-low.
- pow  input  1  power switch, level, high = on, synchronous to clk.
- key_str  input  1  raw start key, active-low, asynchronous, bouncing.
- key_pas  input  1  raw pause key, active-low, asynchronous, bouncing.
- key_rst  input  1  raw soft-clear key, active-low, asynchronous, bouncing.
- run  output  1  high while state is RUN.
- tick  output  1  one-cycle pulse per TICK_DIV cycles in RUN; count enable for the downstream counter.
- sclr  output  1  one-cycle soft-clear pulse to the downstream counter.
- state  output  2  current FSM state: OFF=0, IDLE=1, RUN=2, PAUSED=3.

Function
REQ-004 Each key SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-005 Debouncer: when the synchronized level differs from the debounced level for DB_CYCLES consecutive cycles, the debounced level SHALL update; any mismatch-free cycle clears the stability counter to 0.
REQ-006 A press event SHALL be a single-cycle pulse on the debounced 1->0 transition. No event on release. A held key SHALL give exactly one event.
REQ-007 Latency from a clean raw edge to the press event SHALL be DB_CYCLES+3 cycles, +/-1.
REQ-008 FSM transitions SHALL be evaluated every cycle, in this priority:
- (1) pow=0: any state -> OFF.
- (2) rst event in IDLE/RUN/PAUSED -> IDLE.
- (3) pas event in RUN -> PAUSED.
- (4) str event in IDLE or PAUSED -> RUN.
- (5) OFF with pow=1 -> IDLE.
REQ-009 Events not listed for the current state SHALL be ignored. Examples: str in RUN, pas in IDLE/PAUSED, any key event in OFF.
REQ-010 Simultaneous str and pas events in the same cycle: pas SHALL win in RUN; str SHALL win in PAUSED (pas not applicable there).
REQ-011 sclr SHALL pulse for exactly one cycle, registered, the cycle after an accepted rst event. sclr SHALL also pulse on every OFF->IDLE transition.
REQ-012 Tick divider is a counter, width ceil(log2(TICK_DIV)):
- RUN: increments 0..TICK_DIV-1 and wraps to 0.
- tick SHALL be high in the cycle after the counter reads TICK_DIV-1 (registered).
REQ-013 Divider in PAUSED SHALL hold its value, so tick phase resumes on re-entering RUN. Divider in IDLE/OFF SHALL be cleared to 0.
REQ-014 tick SHALL never assert outside RUN, including the cycle after leaving RUN.
REQ-015 tick and sclr SHALL never assert in the same cycle.
REQ-016 run and state SHALL be registered, updating the cycle after the transition condition.

Reset
REQ-017 clr low SHALL asynchronously force:
- state=OFF, run=0, tick=0, sclr=0;
- all counters 0;
- synchronizer and debounced levels 1 (released).
REQ-018 After clr deasserts, no press event SHALL be generated unless a key is actually pressed.
REQ-019 clr asserted mid-RUN SHALL abort immediately with no trailing tick or sclr pulse.

Structure
REQ-020 The shared package SHALL hold:
- state encoding constants OFF/IDLE/RUN/PAUSED;
- default values of DB_CYCLES and TICK_DIV.
REQ-021 A sub-module key_debounce SHALL implement one key's synchronizer, debouncer and press-event pulse. It SHALL be instantiated three times.
REQ-022 The FSM and tick divider SHALL reside in stopwatch_ctrl.

Verification (DB_CYCLES=4, TICK_DIV=5)
REQ-023 Stimulus: reset, pow=1, key_str pressed clean. Required response: state OFF->IDLE with one sclr pulse, then RUN 7+/-1 cycles after the press; first tick 5 cycles later, then every 5 cycles.
REQ-024 Stimulus: key_str toggles every 2 cycles for 20 cycles, then held low. Required response: exactly one press event; state enters RUN once.
REQ-025 Stimulus: in RUN with divider=3, press pas, hold 10 cycles, press str. Required response: no tick while PAUSED; first tick after resume 2 cycles after RUN re-entry.
REQ-026 Stimulus: str and pas events in the same cycle, in RUN and in PAUSED. Required response: RUN->PAUSED; PAUSED->RUN.
REQ-027 Stimulus: rst press in RUN. Required response: state IDLE, one sclr pulse, tick stays 0, divider 0.
REQ-028 Stimulus: pow dropped in RUN; separately, clr pulsed in RUN. Required response: pow case gives OFF the next cycle, no further tick; clr case gives all outputs 0 immediately.
